bip_debug_unit: RTL and testbench

Host-facing sequencer for the BIP core: it sits between the UART byte interface and the BIP program memory and control unit. It decodes host command bytes, streams a program image into instruction memory, and runs the core until it decodes HALT. It then returns a PC/ACC/cycle-count report to the host over the UART transmitter. It owns the BIP's reset and valid (clock-enable) inputs, so it is the only agent that starts or stops the processor.

---
 rtl/bip_debug_unit_if.sv | 31 +++
 rtl/bip_debug_unit.sv | 191 +++++++++++++++++++
 tb/tb_bip_debug_unit.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/bip_debug_unit_if.sv
// Signal bundle between bip_debug_unit and its UART, program memory and BIP core.
// Names keep the debug unit's i_/o_ view. The master modport is the surrounding system.
interface bip_debug_unit_if #(
  parameter int NB_DATA            = 16,
  parameter int NB_BYTE            = 8,
  parameter int LOG2_N_INSMEM_ADDR = 11
);
  logic [NB_BYTE-1:0]            i_rx_data;
  logic                          i_rx_valid;
  logic [NB_BYTE-1:0]            o_tx_data;
  logic                          o_tx_start;
  logic                          i_tx_done;
  logic [LOG2_N_INSMEM_ADDR-1:0] o_prog_addr;
  logic [NB_DATA-1:0]            o_prog_data;
  logic                          o_prog_we;
  logic                          o_bip_reset;
  logic                          o_bip_valid;
  logic                          i_bip_halt;
  logic [LOG2_N_INSMEM_ADDR-1:0] i_bip_pc;
  logic [NB_DATA-1:0]            i_bip_acc;

  modport slave (
    input  i_rx_data, i_rx_valid, i_tx_done, i_bip_halt, i_bip_pc, i_bip_acc,
    output o_tx_data, o_tx_start, o_prog_addr, o_prog_data, o_prog_we, o_bip_reset, o_bip_valid
  );

  modport master (
    output i_rx_data, i_rx_valid, i_tx_done, i_bip_halt, i_bip_pc, i_bip_acc,
    input  o_tx_data, o_tx_start, o_prog_addr, o_prog_data, o_prog_we, o_bip_reset, o_bip_valid
  );
endinterface

// File: rtl/bip_debug_unit.sv
// Host command sequencer for the BIP core: loads program words, runs the core to HALT,
// and reports PC/ACC/cycle count back over the UART as six big-endian bytes.
module bip_debug_unit #(
  parameter int                 NB_DATA            = 16,
  parameter int                 NB_BYTE            = 8,
  parameter int                 LOG2_N_INSMEM_ADDR = 11,
  parameter int                 NB_CYCLES          = 16,
  parameter logic [NB_BYTE-1:0] CMD_LOAD           = 8'h4C,
  parameter logic [NB_BYTE-1:0] CMD_RUN            = 8'h52
) (
  input  logic            i_clock,
  input  logic            i_reset,
  bip_debug_unit_if.slave bus
);
  localparam int NB_COUNT = 2 * NB_BYTE;

  typedef enum logic [2:0] {
    IDLE, LD_CNT_HI, LD_CNT_LO, LD_HI, LD_LO, RUN, TX_SEND, TX_WAIT
  } state_t;

  state_t                        r_state, w_state_next;
  logic [NB_BYTE-1:0]            r_hi_byte, w_hi_byte_next;
  logic [NB_COUNT-1:0]           r_word_cnt, w_word_cnt_next;
  logic [LOG2_N_INSMEM_ADDR-1:0] r_prog_addr, w_prog_addr_next;
  logic [NB_DATA-1:0]            r_prog_data, w_prog_data_next;
  logic                          r_prog_we, w_prog_we_next;
  logic                          r_bip_reset, w_bip_reset_next;
  logic                          r_bip_valid, w_bip_valid_next;
  logic [NB_CYCLES-1:0]          r_cycles, w_cycles_next;
  logic [NB_DATA-1:0]            r_pc_snap, w_pc_snap_next;
  logic [NB_DATA-1:0]            r_acc_snap, w_acc_snap_next;
  logic [NB_CYCLES-1:0]          r_cyc_snap, w_cyc_snap_next;
  logic [2:0]                    r_byte_idx, w_byte_idx_next;
  logic [NB_BYTE-1:0]            r_tx_data, w_tx_data_next;
  logic                          r_tx_start, w_tx_start_next;
  logic [NB_BYTE-1:0]            w_report_byte;
  logic [NB_COUNT-1:0]           w_rx_word;

  assign w_rx_word = {r_hi_byte, bus.i_rx_data};

  always_comb begin
    case (r_byte_idx)
      3'd0:    w_report_byte = r_pc_snap[NB_DATA-1 -: NB_BYTE];
      3'd1:    w_report_byte = r_pc_snap[NB_BYTE-1:0];
      3'd2:    w_report_byte = r_acc_snap[NB_DATA-1 -: NB_BYTE];
      3'd3:    w_report_byte = r_acc_snap[NB_BYTE-1:0];
      3'd4:    w_report_byte = r_cyc_snap[NB_CYCLES-1 -: NB_BYTE];
      default: w_report_byte = r_cyc_snap[NB_BYTE-1:0];
    endcase
  end

  always_comb begin
    w_state_next     = r_state;
    w_hi_byte_next   = r_hi_byte;
    w_word_cnt_next  = r_word_cnt;
    // The address advances after the write cycle so it stays stable while o_prog_we is high.
    w_prog_addr_next = r_prog_we ? r_prog_addr + LOG2_N_INSMEM_ADDR'(1) : r_prog_addr;
    w_prog_data_next = r_prog_data;
    w_prog_we_next   = 1'b0;
    w_cycles_next    = r_cycles;
    w_pc_snap_next   = r_pc_snap;
    w_acc_snap_next  = r_acc_snap;
    w_cyc_snap_next  = r_cyc_snap;
    w_byte_idx_next  = r_byte_idx;
    w_tx_data_next   = r_tx_data;
    w_tx_start_next  = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.i_rx_valid && (bus.i_rx_data == CMD_LOAD)) begin
          w_state_next = LD_CNT_HI;
        end else if (bus.i_rx_valid && (bus.i_rx_data == CMD_RUN)) begin
          w_state_next  = RUN;
          w_cycles_next = {NB_CYCLES{1'b0}};
        end else begin
          w_state_next = IDLE;
        end
      end
      LD_CNT_HI: begin
        if (bus.i_rx_valid) begin
          w_hi_byte_next = bus.i_rx_data;
          w_state_next   = LD_CNT_LO;
        end else begin
          w_state_next = LD_CNT_HI;
        end
      end
      LD_CNT_LO: begin
        if (bus.i_rx_valid && (w_rx_word == {NB_COUNT{1'b0}})) begin
          w_state_next = IDLE;
        end else if (bus.i_rx_valid) begin
          w_word_cnt_next  = w_rx_word;
          w_prog_addr_next = {LOG2_N_INSMEM_ADDR{1'b0}};
          w_state_next     = LD_HI;
        end else begin
          w_state_next = LD_CNT_LO;
        end
      end
      LD_HI: begin
        if (bus.i_rx_valid) begin
          w_hi_byte_next = bus.i_rx_data;
          w_state_next   = LD_LO;
        end else begin
          w_state_next = LD_HI;
        end
      end
      LD_LO: begin
        if (bus.i_rx_valid) begin
          w_prog_data_next = NB_DATA'(w_rx_word);
          w_prog_we_next   = 1'b1;
          w_word_cnt_next  = r_word_cnt - NB_COUNT'(1);
          w_state_next     = (r_word_cnt == NB_COUNT'(1)) ? IDLE : LD_HI;
        end else begin
          w_state_next = LD_LO;
        end
      end
      RUN: begin
        if (bus.i_bip_halt) begin
          w_pc_snap_next  = NB_DATA'(bus.i_bip_pc);
          w_acc_snap_next = bus.i_bip_acc;
          w_cyc_snap_next = r_cycles;
          w_byte_idx_next = 3'd0;
          w_state_next    = TX_SEND;
        end else begin
          w_cycles_next = (r_cycles == {NB_CYCLES{1'b1}}) ? r_cycles : r_cycles + NB_CYCLES'(1);
        end
      end
      TX_SEND: begin
        w_tx_data_next  = w_report_byte;
        w_tx_start_next = 1'b1;
        w_state_next    = TX_WAIT;
      end
      TX_WAIT: begin
        if (bus.i_tx_done && (r_byte_idx == 3'd5)) begin
          w_state_next = IDLE;
        end else if (bus.i_tx_done) begin
          w_byte_idx_next = r_byte_idx + 3'd1;
          w_state_next    = TX_SEND;
        end else begin
          w_state_next = TX_WAIT;
        end
      end
      default: w_state_next = IDLE;
    endcase
    // Core controls follow the state being entered so they change together with it.
    w_bip_reset_next = !((w_state_next == RUN) || (w_state_next == TX_SEND) || (w_state_next == TX_WAIT));
    w_bip_valid_next = (w_state_next == RUN);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_hi_byte   <= {NB_BYTE{1'b0}};
      r_word_cnt  <= {NB_COUNT{1'b0}};
      r_prog_addr <= {LOG2_N_INSMEM_ADDR{1'b0}};
      r_prog_data <= {NB_DATA{1'b0}};
      r_prog_we   <= 1'b0;
      r_bip_reset <= 1'b1;
      r_bip_valid <= 1'b0;
      r_cycles    <= {NB_CYCLES{1'b0}};
      r_pc_snap   <= {NB_DATA{1'b0}};
      r_acc_snap  <= {NB_DATA{1'b0}};
      r_cyc_snap  <= {NB_CYCLES{1'b0}};
      r_byte_idx  <= 3'd0;
      r_tx_data   <= {NB_BYTE{1'b0}};
      r_tx_start  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_hi_byte   <= w_hi_byte_next;
      r_word_cnt  <= w_word_cnt_next;
      r_prog_addr <= w_prog_addr_next;
      r_prog_data <= w_prog_data_next;
      r_prog_we   <= w_prog_we_next;
      r_bip_reset <= w_bip_reset_next;
      r_bip_valid <= w_bip_valid_next;
      r_cycles    <= w_cycles_next;
      r_pc_snap   <= w_pc_snap_next;
      r_acc_snap  <= w_acc_snap_next;
      r_cyc_snap  <= w_cyc_snap_next;
      r_byte_idx  <= w_byte_idx_next;
      r_tx_data   <= w_tx_data_next;
      r_tx_start  <= w_tx_start_next;
    end
  end

  assign bus.o_tx_data   = r_tx_data;
  assign bus.o_tx_start  = r_tx_start;
  assign bus.o_prog_addr = r_prog_addr;
  assign bus.o_prog_data = r_prog_data;
  assign bus.o_prog_we   = r_prog_we;
  assign bus.o_bip_reset = r_bip_reset;
  assign bus.o_bip_valid = r_bip_valid;
endmodule

// File: tb/tb_bip_debug_unit.sv
// Scoreboard bench for bip_debug_unit with a tiny BIP core model and a UART transmitter model.
module tb_bip_debug_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bip_debug_unit_if bus ();
  bip_debug_unit dut (.i_clock(clk), .i_reset(rst), .bus(bus));

  int n_compared   = 0;
  int n_mismatched = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Mini BIP: pc0 loads 4, pc1 stores, pc2 adds 3, halt decoded at halt_pc.
  logic [10:0] m_pc;
  logic [15:0] m_acc;
  logic        halt_en = 1'b0;
  logic        freeze  = 1'b0;
  logic [10:0] halt_pc = 11'd3;
  assign bus.i_bip_pc   = m_pc;
  assign bus.i_bip_acc  = m_acc;
  assign bus.i_bip_halt = halt_en && (m_pc == halt_pc);
  always @(posedge clk) begin
    if (bus.o_bip_reset) begin
      m_pc  <= 11'd0;
      m_acc <= 16'd0;
    end else if (bus.o_bip_valid && !bus.i_bip_halt && !freeze) begin
      m_pc <= m_pc + 11'd1;
      if (m_pc == 11'd0) m_acc <= 16'd4;
      else if (m_pc == 11'd2) m_acc <= m_acc + 16'd3;
    end
  end

  logic [26:0] wq[$];
  logic [7:0]  tq[$];
  logic [26:0] w_exp;
  int we_count = 0, exec_cnt = 0, halt_cyc = -1;
  logic [10:0] last_we_addr = 11'd0;

  // Program-write scoreboard and run/halt timing, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.o_prog_we) begin
      we_count++;
      last_we_addr = bus.o_prog_addr;
      if (wq.size() == 0) check_val("unexpected_we", 32'd1, 32'd0);
      else begin
        w_exp = wq.pop_front();
        check_val("prog_addr", bus.o_prog_addr, w_exp[26:16]);
        check_val("prog_data", bus.o_prog_data, w_exp[15:0]);
      end
    end
    if (bus.o_bip_valid && !bus.i_bip_halt) exec_cnt++;
    if (bus.o_bip_valid && bus.i_bip_halt) halt_cyc = cyc;
    if (halt_cyc >= 0 && cyc == halt_cyc + 1) check_val("valid_drop", bus.o_bip_valid, 32'd0);
    if (halt_cyc >= 0 && cyc == halt_cyc + 2) check_val("halt_to_start", bus.o_tx_start, 32'd1);
  end

  int tx_starts = 0, done_cyc = -1, tx_timer = 0;
  bit tx_busy = 1'b0;
  // UART transmitter: done pulse four cycles after each start; checks bytes and hand-off.
  initial begin
    bus.i_tx_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.i_tx_done = 1'b0;
      if (tx_busy) begin
        if (tx_timer == 0) begin
          bus.i_tx_done = 1'b1;
          tx_busy       = 1'b0;
          done_cyc      = cyc;
        end else tx_timer--;
      end
      if (bus.o_tx_start) begin
        tx_starts++;
        check_val("tx_overlap", tx_busy, 32'd0);
        if (done_cyc > halt_cyc) check_val("tx_latency", cyc - done_cyc, 32'd2);
        if (tq.size() == 0) check_val("unexpected_tx", 32'd1, 32'd0);
        else check_val("tx_byte", bus.o_tx_data, tq.pop_front());
        tx_busy  = 1'b1;
        tx_timer = 3;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.i_rx_data  = b;
    bus.i_rx_valid = 1'b1;
    tick();
    bus.i_rx_valid = 1'b0;
  endtask

  task automatic push_report(input logic [15:0] pc, input logic [15:0] acc, input logic [15:0] cy);
    tq.push_back(pc[15:8]);  tq.push_back(pc[7:0]);
    tq.push_back(acc[15:8]); tq.push_back(acc[7:0]);
    tq.push_back(cy[15:8]);  tq.push_back(cy[7:0]);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while ((tq.size() != 0 || tx_busy || !bus.o_bip_reset) && n < budget) begin
      tick();
      n++;
    end
    check_val(tag, (n < budget), 32'd1);
  endtask

  initial begin
    logic [7:0]  load_bytes[7] = '{8'h4C, 8'h00, 8'h02, 8'h08, 8'h05, 8'h18, 8'h03};
    logic [15:0] d;
    int          e0, s1, n;
    rst = 1'b1;
    bus.i_rx_valid = 1'b0;
    bus.i_rx_data  = 8'h00;
    tick(); tick();
    check_val("rst_bip_reset", bus.o_bip_reset, 32'd1);
    check_val("rst_bip_valid", bus.o_bip_valid, 32'd0);
    check_val("rst_prog_we",   bus.o_prog_we,   32'd0);
    check_val("rst_prog_addr", bus.o_prog_addr, 32'd0);
    check_val("rst_tx_start",  bus.o_tx_start,  32'd0);
    check_val("rst_tx_data",   bus.o_tx_data,   32'd0);
    rst = 1'b0;
    tick();

    // Two-word load at full byte rate
    wq.push_back({11'd0, 16'h0805});
    wq.push_back({11'd1, 16'h1803});
    foreach (load_bytes[i]) send_byte(load_bytes[i]);
    repeat (3) tick();
    check_val("load_we_count", we_count, 32'd2);
    check_val("load_drained", wq.size(), 32'd0);

    // Unknown bytes in IDLE
    send_byte(8'h41);
    send_byte(8'h00);
    repeat (3) tick();
    check_val("ignore_we_count", we_count, 32'd2);
    check_val("ignore_bip_reset", bus.o_bip_reset, 32'd1);
    check_val("ignore_bip_valid", bus.o_bip_valid, 32'd0);

    // Run to HALT at pc 3; a load command sent during RUN must be dropped
    halt_pc = 11'd3; halt_en = 1'b1; freeze = 1'b0;
    e0 = exec_cnt;
    push_report(16'h0003, 16'h0007, 16'h0003);
    send_byte(8'h52);
    check_val("run_valid", bus.o_bip_valid, 32'd1);
    check_val("run_bip_reset", bus.o_bip_reset, 32'd0);
    send_byte(8'h4C);
    send_byte(8'h00);
    send_byte(8'h01);
    wait_done("run_report_done", 300);
    check_val("run_exec_cycles", exec_cnt - e0, 32'd3);
    check_val("run_no_we", we_count, 32'd2);

    // Counter saturation
    halt_en = 1'b0; freeze = 1'b1; halt_pc = 11'd0;
    push_report(16'h0000, 16'h0000, 16'hFFFF);
    send_byte(8'h52);
    repeat (70000) tick();
    halt_en = 1'b1;
    wait_done("sat_report_done", 300);
    freeze = 1'b0;

    // Zero-count load, then a one-word load proves IDLE was reached
    send_byte(8'h4C); send_byte(8'h00); send_byte(8'h00);
    repeat (2) tick();
    check_val("zero_no_we", we_count, 32'd2);
    wq.push_back({11'd0, 16'h1234});
    send_byte(8'h4C); send_byte(8'h00); send_byte(8'h01); send_byte(8'h12); send_byte(8'h34);
    repeat (3) tick();
    check_val("one_we_count", we_count, 32'd3);

    // 2049 words: address wraps, last word lands at 0
    send_byte(8'h4C); send_byte(8'h08); send_byte(8'h01);
    for (int i = 0; i < 2049; i++) begin
      d = 16'(i * 37 + 5);
      wq.push_back({11'(i), d});
      send_byte(d[15:8]);
      send_byte(d[7:0]);
    end
    repeat (3) tick();
    check_val("wrap_we_count", we_count, 32'd2052);
    check_val("wrap_drained", wq.size(), 32'd0);
    check_val("wrap_last_addr", last_we_addr, 32'd0);

    // Reset after third report byte
    halt_pc = 11'd3; halt_en = 1'b1;
    tq.push_back(8'h00); tq.push_back(8'h03); tq.push_back(8'h00);
    s1 = tx_starts;
    send_byte(8'h52);
    n = 0;
    while (tx_starts < s1 + 3 && n < 200) begin
      tick();
      n++;
    end
    check_val("midtx_reached", (n < 200), 32'd1);
    rst = 1'b1;
    tick();
    check_val("midtx_bip_reset", bus.o_bip_reset, 32'd1);
    check_val("midtx_tx_start", bus.o_tx_start, 32'd0);
    check_val("midtx_bip_valid", bus.o_bip_valid, 32'd0);
    rst = 1'b0;
    s1 = tx_starts;
    repeat (60) tick();
    check_val("midtx_no_more_tx", tx_starts, s1);
    check_val("midtx_queue", tq.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule
